// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device transmitter.
//
// Sends one command byte (e.g. 0xED LED set, 0xF4 enable) to a PS/2 device
// over the shared open-drain clock/data pair. The host inhibits the bus,
// issues request-to-send, then shifts out data bits on device clock falls.
// It checks the device ack and reports success or failure via one-cycle pulses.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-low reset; releases both lines at once
//   start       one-cycle send request, honoured only while idle
//   in[23:0]    command word; in[7:0] is the byte sent, in[23:8] unused
//   ps2clk_in   raw PS/2 clock pin level
//   ps2data_in  raw PS/2 data pin level
//   ps2clk_oe   1 = pull PS/2 clock low, 0 = release
//   ps2data_oe  1 = pull PS/2 data low, 0 = release
//   busy        high from the cycle after an accepted start until done/fail
//   rdy         one-cycle pulse: byte sent and acknowledged
//   err         one-cycle pulse: timeout or missing ack
//   irq         rdy | err
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER         = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] in,
    input  logic        ps2clk_in,
    input  logic        ps2data_in,
    output logic        ps2clk_oe,
    output logic        ps2data_oe,
    output logic        busy,
    output logic        rdy,
    output logic        err,
    output logic        irq
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int FW = $clog2(FILTER + 1);

    // Index of the bit counter after the parity bit has been put on the line.
    localparam logic [3:0] LAST_BIT = 4'd9;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        BITS,
        STOP,
        WAIT_IDLE,
        DONE,
        FAIL
    } state_t;

    state_t state, nxt;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic clk_s1, clk_s2, dat_s1, dat_s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s1 <= 1'b0;
            clk_s2 <= 1'b0;
            dat_s1 <= 1'b0;
            dat_s2 <= 1'b0;
        end else begin
            clk_s1 <= ps2clk_in;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2data_in;
            dat_s2 <= dat_s1;
        end
    end

    // Glitch filter: the filtered clock only follows the synchronized level
    // once it has disagreed for FILTER consecutive samples. Any sample that
    // agrees again restarts the count, so short spikes never get through.
    logic          clk_f, clk_f_d;
    logic [FW-1:0] flt_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_f   <= 1'b0;
            clk_f_d <= 1'b0;
            flt_cnt <= '0;
        end else begin
            clk_f_d <= clk_f;
            if (clk_s2 == clk_f) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER - 1)) begin
                clk_f   <= clk_s2;
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    // Device falling edge, as seen after sync + filter.
    logic fall;
    assign fall = clk_f_d & ~clk_f;

    // ------------------------------------------------------------------
    // Datapath: inhibit timer, edge timeout, shift register
    // ------------------------------------------------------------------
    logic [IW-1:0] inh_cnt;
    logic          inh_last;
    logic [TW-1:0] tmo;
    logic          tmo_zero;
    logic          timed;
    logic [8:0]    shreg;     // {parity, data}, shifted out LSB first
    logic [3:0]    bit_cnt;   // bits already placed on the line
    logic          cur_bit;   // level currently presented for the device

    assign inh_last = (inh_cnt == IW'(INHIBIT_CYCLES - 1));
    assign tmo_zero = (tmo == '0);
    assign timed    = (state == REQ) || (state == BITS) ||
                      (state == STOP) || (state == WAIT_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inh_cnt <= '0;
        end else if (state == INHIBIT) begin
            inh_cnt <= inh_cnt + 1'b1;
        end else begin
            inh_cnt <= '0;
        end
    end

    // The timer sits preloaded outside the timed states, so it starts
    // fresh on REQ entry, and it reloads on every fall. The preload is one
    // less than the limit so that expiry lands exactly TIMEOUT_CYCLES
    // cycles after the last reload.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo <= '0;
        end else if (!timed || fall) begin
            tmo <= TW'(TIMEOUT_CYCLES - 1);
        end else if (!tmo_zero) begin
            tmo <= tmo - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
            cur_bit <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                shreg   <= {~^in[7:0], in[7:0]};
                bit_cnt <= '0;
                cur_bit <= 1'b0;
            end
        end else if (fall && ((state == REQ) ||
                              (state == BITS && bit_cnt != LAST_BIT))) begin
            // The first fall presents data[0]; later falls present the
            // remaining data bits and then parity.
            cur_bit <= shreg[0];
            shreg   <= {1'b1, shreg[8:1]};
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Upper command bits are carried by the decode but carry no meaning here.
    logic unused_in;
    assign unused_in = ^in[23:8];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    // Timeout checks are all placed behind the fall checks: a fall in the
    // expiry cycle wins and the timer simply reloads.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:      if (start) nxt = INHIBIT;
            INHIBIT:   if (inh_last) nxt = REQ;
            REQ: begin
                if (fall)          nxt = BITS;
                else if (tmo_zero) nxt = FAIL;
            end
            BITS: begin
                if (fall) begin
                    if (bit_cnt == LAST_BIT) nxt = STOP;
                end else if (tmo_zero) begin
                    nxt = FAIL;
                end
            end
            STOP: begin
                // Ack slot: the device must hold data low at this fall.
                if (fall)          nxt = dat_s2 ? FAIL : WAIT_IDLE;
                else if (tmo_zero) nxt = FAIL;
            end
            WAIT_IDLE: begin
                if (clk_f && dat_s2)       nxt = DONE;
                else if (!fall && tmo_zero) nxt = FAIL;
            end
            DONE:      nxt = IDLE;
            FAIL:      nxt = IDLE;
            default:   nxt = IDLE;
        endcase
    end

    // Outputs are decoded from state only, so an asynchronous reset releases
    // both lines immediately, even mid-frame.
    always_comb begin
        ps2clk_oe  = 1'b0;
        ps2data_oe = 1'b0;
        busy       = 1'b0;
        rdy        = 1'b0;
        err        = 1'b0;
        case (state)
            INHIBIT: begin
                ps2clk_oe  = 1'b1;
                ps2data_oe = inh_last;   // start bit goes down just before release
                busy       = 1'b1;
            end
            REQ: begin
                ps2data_oe = 1'b1;
                busy       = 1'b1;
            end
            BITS: begin
                ps2data_oe = ~cur_bit;
                busy       = 1'b1;
            end
            STOP:      busy = 1'b1;
            WAIT_IDLE: busy = 1'b1;
            DONE:      rdy  = 1'b1;
            FAIL:      err  = 1'b1;
            default: ;
        endcase
        irq = rdy | err;
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TMO = 2000;
    localparam int FLT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [23:0] in_w = '0;
    logic        dev_clk_low = 1'b0;
    logic        dev_dat_low = 1'b0;
    logic        ps2clk_in, ps2data_in;
    logic        ps2clk_oe, ps2data_oe, busy, rdy, err, irq;

    // Open-drain wires with pull-ups.
    assign ps2clk_in  = ~(ps2clk_oe  | dev_clk_low);
    assign ps2data_in = ~(ps2data_oe | dev_dat_low);

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER(FLT)) dut (
        .clk(clk), .rst(rst), .start(start), .in(in_w),
        .ps2clk_in(ps2clk_in), .ps2data_in(ps2data_in),
        .ps2clk_oe(ps2clk_oe), .ps2data_oe(ps2data_oe),
        .busy(busy), .rdy(rdy), .err(err), .irq(irq)
    );

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [10:0] got_q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad   = 0;

    // Reference frame as the device should see it, bit 0 first on the wire:
    // start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] ref_frame(input logic [7:0] d);
        int   ones = 0;
        logic par;
        for (int i = 0; i < 8; i++) if (d[i]) ones++;
        par = (ones % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, d, 1'b0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every completion pulse pops one expected outcome.
    always @(negedge clk) begin
        if (rst && (rdy || err || irq)) begin
            check("irq_is_rdy_or_err", irq, rdy | err);
            check("busy_low_at_end", busy, 0);
            check("lines_released_at_end", {ps2clk_oe, ps2data_oe}, 0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event rdy=%0b err=%0b required=none", rdy, err);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_err", err, mon_e.is_err);
                check("event_rdy", rdy, !mon_e.is_err);
                if (!mon_e.is_err) begin
                    if (got_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL frame_missing actual=none required=%0h", ref_frame(mon_e.data));
                    end else begin
                        check("frame_bits", got_q.pop_front(), ref_frame(mon_e.data));
                    end
                end
            end
        end
    end

    // Device model: watches the inhibit / request-to-send, then clocks out
    // npulses pulses, sampling data on rising edges and acking on pulse 11.
    task automatic dev_run(input int half, input int npulses, input bit ack_ok, input int glitch_p);
        int          n;
        logic [10:0] frame;
        n = 0;
        while (!ps2clk_oe && n < 200) begin @(negedge clk); n++; end
        if (!ps2clk_oe) begin
            total++; bad++;
            $display("FAIL inhibit_start actual=none required=clock_low");
            return;
        end
        n = 0;
        while (ps2clk_oe && n < INH * 4) begin n++; @(negedge clk); end
        check("inhibit_len", n, INH);
        check("rts_data_oe", ps2data_oe, 1);
        frame    = '0;
        frame[0] = ps2data_in;
        if (npulses == 0) return;
        repeat (half) @(negedge clk);
        for (int p = 1; p <= npulses; p++) begin
            dev_clk_low = 1'b1;
            if (p == 11 && ack_ok) dev_dat_low = 1'b1;
            repeat (half) @(negedge clk);
            if (p <= 10) frame[p] = ps2data_in;
            if (p == 11 && ack_ok) got_q.push_back(frame);
            dev_clk_low = 1'b0;
            dev_dat_low = 1'b0;
            if (p == glitch_p) begin
                repeat (half / 2) @(negedge clk);
                dev_clk_low = 1'b1;
                @(negedge clk);
                dev_clk_low = 1'b0;
                repeat (half - half / 2 - 1) @(negedge clk);
            end else begin
                repeat (half) @(negedge clk);
            end
        end
    endtask

    task automatic send(input logic [7:0] d, input bit is_err, input bit push);
        @(negedge clk);
        in_w  = {16'($urandom), d};
        start = 1'b1;
        if (push) exp_q.push_back(exp_t'({is_err, d}));
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("clk_oe_after_start", ps2clk_oe, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 5000) begin @(negedge clk); n++; end
        if (busy) begin
            total++; bad++;
            $display("FAIL wait_idle actual=busy required=idle");
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int n;
        logic [7:0] d;
        int half, glitch;
        bit nack;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_clk_oe", ps2clk_oe, 0);
        check("rst_data_oe", ps2data_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_irq", {rdy, err, irq}, 0);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        // 0xED and 0xF4 with acks
        fork dev_run(40, 11, 1'b1, 0); send(8'hED, 1'b0, 1'b1); join
        wait_idle();
        fork dev_run(40, 11, 1'b1, 0); send(8'hF4, 1'b0, 1'b1); join
        wait_idle();

        // Device silent after request-to-send: timeout
        fork dev_run(40, 0, 1'b1, 0); send(8'h5A, 1'b1, 1'b1); join
        n = 0;
        while (!err && n < TMO + 1000) begin @(negedge clk); n++; end
        total++;
        if (n < TMO || n > TMO + FLT + 4) begin
            bad++;
            $display("FAIL timeout_latency actual=%0d required=%0d..%0d", n, TMO, TMO + FLT + 4);
        end
        wait_idle();

        // Missing ack, then a normal frame
        fork dev_run(40, 11, 1'b0, 0); send(8'hA3, 1'b1, 1'b1); join
        wait_idle();
        check("idle_after_nack", {busy, ps2clk_oe, ps2data_oe}, 0);
        fork dev_run(40, 11, 1'b1, 0); send(8'h01, 1'b0, 1'b1); join
        wait_idle();

        // Asynchronous reset mid-frame
        fork dev_run(40, 4, 1'b1, 0); send(8'h00, 1'b0, 1'b0); join
        check("bits_data_oe_before_rst", ps2data_oe, 1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_clk_oe", ps2clk_oe, 0);
        check("async_rst_data_oe", ps2data_oe, 0);
        check("async_rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (50) @(negedge clk);
        check("post_rst_busy", busy, 0);

        // Second start while busy, plus a one-cycle clock glitch
        fork
            dev_run(40, 11, 1'b1, 4);
            begin
                send(8'h6C, 1'b0, 1'b1);
                repeat (5) @(negedge clk);
                in_w  = 24'h000099;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        wait_idle();

        // Randomized frames
        for (int k = 0; k < 8; k++) begin
            d      = 8'($urandom);
            half   = $urandom_range(15, 45);
            nack   = ($urandom_range(0, 4) == 0);
            glitch = $urandom_range(0, 10);
            fork dev_run(half, 11, !nack, glitch); send(d, nack, 1'b1); join
            wait_idle();
        end

        check("exp_q_drained", exp_q.size(), 0);
        check("got_q_drained", got_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter, the send side paired with the existing keyboard receiver. It carries commands such as LED set (0xED) and enable (0xF4) from the CPU to the keyboard. A 24-bit word arrives from connectorGraphics-style decode: a `start` pulse plus the payload in `in[7:0]`. The block drives the shared `ps2clk`/`ps2data` lines open-drain and raises `irq` on completion or error.

Parameters:
INHIBIT_CYCLES, 5000, clock-low hold before request-to-send (100 us at 50 MHz).
TIMEOUT_CYCLES, 750000, maximum clk cycles allowed between successive device falling edges, and between request-to-send and the first edge (15 ms).
FILTER, 4, consecutive equal synchronized samples needed to accept a new `ps2clk` level.

Ports:
clk  in  1  system clock (iclk domain)
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle request; sampled only in IDLE
in  in  24  command word; bits [7:0] are the byte to send, [23:8] are ignored
ps2clk_in  in  1  raw PS/2 clock pin level
ps2data_in  in  1  raw PS/2 data pin level
ps2clk_oe  out  1  1 = pull PS/2 clock low; 0 = release
ps2data_oe  out  1  1 = pull PS/2 data low; 0 = release
busy  out  1  high from the cycle after accepted `start` until return to IDLE
rdy  out  1  one-cycle pulse: byte sent and acknowledged
err  out  1  one-cycle pulse: timeout or missing ack
irq  out  1  one-cycle pulse, equal to rdy | err

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs are 0 immediately, so both lines are released, including mid-frame. The shift register, counters and filters are cleared.
- Input conditioning: `ps2clk_in` and `ps2data_in` each pass through a 2-FF synchronizer. `ps2clk` then goes through the FILTER-sample glitch filter. A device falling edge ("fall") is a filtered 1->0 transition. Added latency is 2+FILTER cycles.
- Frame: 11 bits, LSB first. Start bit 0, data 8 bits, odd parity (bit = ~^data), stop bit 1. The device then drives an ack 0.
- On accepted start:
  - latch `in[7:0]`;
  - compute parity;
  - busy=1 and ps2clk_oe=1 on the next cycle.
- FSM states and transitions:
  - IDLE: start=1 -> INHIBIT. A start in any other state is ignored and not queued.
  - INHIBIT: ps2clk_oe=1 for INHIBIT_CYCLES cycles. On the last cycle assert ps2data_oe=1 (start bit) -> REQ.
  - REQ: ps2clk_oe=0, ps2data_oe=1. Timer cleared. First fall -> BITS and drive bit0 (ps2data_oe = ~data[0]).
  - BITS: each fall advances one bit: data[1..7], then parity. ps2data_oe is updated in the cycle after the fall is detected. After the parity bit, the next fall -> STOP with ps2data_oe=0.
  - STOP: the next fall is the ack slot. Sample the synchronized data at that fall. Data=0 -> WAIT_IDLE. Data=1 -> FAIL.
  - WAIT_IDLE: wait until filtered clk=1 and synchronized data=1 -> DONE.
  - DONE: rdy=1 and irq=1 for one cycle; busy=0 -> IDLE.
  - FAIL: release both lines; err=1 and irq=1 for one cycle; busy=0 -> IDLE.
- Timeout: in REQ, BITS, STOP and WAIT_IDLE, a down-counter reloads to TIMEOUT_CYCLES on every fall. Reaching 0 -> FAIL.
- Count rule: exactly 11 falls after INHIBIT (start-bit edge, 8 data, parity, stop, then ack). A bit counter of 4 bits wraps nowhere, because the FSM exits at 11.
- Open-drain rule: an output is never driven high, only low (oe=1) or released (oe=0).
- Start and reset together: reset wins.
- Fall on the same cycle as timeout expiry: the fall wins and the counter reloads.

Test Plan:
1. Bench with INHIBIT_CYCLES=20, TIMEOUT_CYCLES=2000, FILTER=2. Set in=0x0000ED, start; device model clocks at 80 cycles per period and acks -> ps2clk_oe high for 20 cycles; then data bits sampled on rising edges are 0, 1,0,1,1,0,1,1,1, 1 (parity), 1 (stop). Then rdy=irq=1 for one cycle and busy falls.
2. in=0x0000F4 -> device receives LSB-first 0,0,1,0,1,1,1,1; parity 0; rdy pulse.
3. Device never clocks after request -> lines released and err=irq=1 exactly 2000 cycles (+ sync latency) after REQ entry; rdy stays 0.
4. Device holds data high in the ack slot -> err pulse; both oe=0; FSM back in IDLE and accepts a new start (0x01, parity 0) that completes normally.
5. Assert rst=0 while in BITS with ps2data_oe=1 -> ps2data_oe and ps2clk_oe go 0 before the next clk edge. After rst=1: busy=0, no rdy/err pulse.
6. Second start pulse during busy plus a 1-cycle ps2clk glitch -> second start ignored (exactly one frame sent), glitch not counted as a fall, and transmitted byte unchanged.
